alu_operand_collector: RTL and testbench

- Upstream stage of the ALU: accepts operation beats whose operands may arrive in separate cycles, merges them, and issues one complete, protocol-clean operation to the ALU.
- Drives ALU `ce`/`mode`/`cmd`/`cin`/`opa`/`opb`/`inp_valid`.
- Enforces the retry window for two-operand commands: the second operand must arrive within TIMEOUT cycles.
- Holds ALU inputs stable and `ce` low while the ALU result settles.

---
 rtl/alu_collector_pkg.sv | 63 ++++++
 rtl/alu_operand_collector_if.sv | 39 +++
 rtl/alu_cmd_classifier.sv | 22 ++
 rtl/alu_operand_collector.sv | 188 ++++++++++++++++++
 tb/tb_alu_operand_collector.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_collector_pkg.sv
// Shared types, command encodings and operand-requirement helpers for the ALU operand collector.
// Optional build feature: ALU_COLLECTOR_STATS_EN (issue/timeout/drop counters on the top).
package alu_collector_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned STAT_W = 16;

   // Arithmetic commands (mode = 1)
   localparam logic [CMD_W-1:0] ADD     = CMD_W'(0);
   localparam logic [CMD_W-1:0] SUB     = CMD_W'(1);
   localparam logic [CMD_W-1:0] ADD_CIN = CMD_W'(2);
   localparam logic [CMD_W-1:0] SUB_CIN = CMD_W'(3);
   localparam logic [CMD_W-1:0] INC_A   = CMD_W'(4);
   localparam logic [CMD_W-1:0] DEC_A   = CMD_W'(5);
   localparam logic [CMD_W-1:0] INC_B   = CMD_W'(6);
   localparam logic [CMD_W-1:0] DEC_B   = CMD_W'(7);
   localparam logic [CMD_W-1:0] CMP     = CMD_W'(8);
   localparam logic [CMD_W-1:0] INC_MUL = CMD_W'(9);
   localparam logic [CMD_W-1:0] SHL_MUL = CMD_W'(10);

   // Logic commands (mode = 0)
   localparam logic [CMD_W-1:0] AND     = CMD_W'(0);
   localparam logic [CMD_W-1:0] NAND    = CMD_W'(1);
   localparam logic [CMD_W-1:0] OR      = CMD_W'(2);
   localparam logic [CMD_W-1:0] NOR     = CMD_W'(3);
   localparam logic [CMD_W-1:0] XOR     = CMD_W'(4);
   localparam logic [CMD_W-1:0] XNOR    = CMD_W'(5);
   localparam logic [CMD_W-1:0] NOT_A   = CMD_W'(6);
   localparam logic [CMD_W-1:0] NOT_B   = CMD_W'(7);
   localparam logic [CMD_W-1:0] SHR1_A  = CMD_W'(8);
   localparam logic [CMD_W-1:0] SHL1_A  = CMD_W'(9);
   localparam logic [CMD_W-1:0] SHR1_B  = CMD_W'(10);
   localparam logic [CMD_W-1:0] SHL1_B  = CMD_W'(11);
   localparam logic [CMD_W-1:0] ROL     = CMD_W'(12);
   localparam logic [CMD_W-1:0] ROR     = CMD_W'(13);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WAIT} state_t;

   function automatic logic cmd_legal(input logic mode, input logic [CMD_W-1:0] cmd);
      return mode ? (cmd <= SHL_MUL) : (cmd <= ROR);
   endfunction

   // bit0 = opa needed, bit1 = opb needed; illegal commands are resolved by the caller
   function automatic logic [1:0] required_mask(input logic mode, input logic [CMD_W-1:0] cmd);
      logic [1:0] m;
      m = 2'b11;
      if (mode) begin
         case (cmd)
            INC_A, DEC_A: m = 2'b01;
            INC_B, DEC_B: m = 2'b10;
            default:      m = 2'b11;
         endcase
      end else begin
         case (cmd)
            NOT_A, SHR1_A, SHL1_A: m = 2'b01;
            NOT_B, SHR1_B, SHL1_B: m = 2'b10;
            default:               m = 2'b11;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Upstream beat bus plus ALU drive bus of the operand collector.
// master = beat producer / ALU-side observer, slave = the collector.
interface alu_operand_collector_if #(
   parameter int unsigned OP_WIDTH  = 8,
   parameter int unsigned CMD_WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_mode;
   logic [CMD_WIDTH-1:0] in_cmd;
   logic                 in_cin;
   logic [1:0]           in_inp_valid;
   logic [OP_WIDTH-1:0]  in_opa;
   logic [OP_WIDTH-1:0]  in_opb;

   logic                 alu_ce;
   logic                 alu_mode;
   logic [CMD_WIDTH-1:0] alu_cmd;
   logic                 alu_cin;
   logic [1:0]           alu_inp_valid;
   logic [OP_WIDTH-1:0]  alu_opa;
   logic [OP_WIDTH-1:0]  alu_opb;

   logic                 busy;
   logic                 timeout_pulse;
   logic                 drop_pulse;

   modport master (
      output in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
      input  in_ready, alu_ce, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb,
      input  busy, timeout_pulse, drop_pulse
   );

   modport slave (
      input  in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
      output in_ready, alu_ce, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb,
      output busy, timeout_pulse, drop_pulse
   );
endinterface

// File: rtl/alu_cmd_classifier.sv
// Combinational decode of {mode, cmd}: operands required, multiply latency class, legality.
module alu_cmd_classifier
   import alu_collector_pkg::*;
#(
   parameter int unsigned CMD_WIDTH = 4
) (
   input  logic                 mode,
   input  logic [CMD_WIDTH-1:0] cmd,
   output logic [1:0]           req_mask_c,
   output logic                 is_mul_c,
   output logic                 cmd_legal_c
);
   logic [CMD_W-1:0] cmd_n;
   logic             cmd_fits;

   // encodings wider than the table are only legal if the extra bits are zero
   assign cmd_n       = CMD_W'(cmd);
   assign cmd_fits    = (CMD_WIDTH'(cmd_n) == cmd);
   assign cmd_legal_c = cmd_fits && cmd_legal(mode, cmd_n);
   assign req_mask_c  = required_mask(mode, cmd_n);
   assign is_mul_c    = cmd_legal_c && mode && ((cmd_n == INC_MUL) || (cmd_n == SHL_MUL));
endmodule

// File: rtl/alu_operand_collector.sv
// Merges split-operand beats into one clean ALU issue, with timeout/drop handling.
// Optional build feature: ALU_COLLECTOR_STATS_EN adds saturating stat_* counters.
module alu_operand_collector
   import alu_collector_pkg::*;
#(
   parameter int unsigned OP_WIDTH  = 8,
   parameter int unsigned CMD_WIDTH = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned ALU_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   alu_operand_collector_if.slave  bus
`ifdef ALU_COLLECTOR_STATS_EN
   ,
   output logic [STAT_W-1:0]       stat_issued,
   output logic [STAT_W-1:0]       stat_timeouts,
   output logic [STAT_W-1:0]       stat_drops
`endif
);
   localparam int unsigned TCW = $clog2(TIMEOUT + 1);
   localparam int unsigned WCW = $clog2(ALU_LAT + 2);

   state_t               state;
   logic                 mode_q, cin_q, mul_q;
   logic [CMD_WIDTH-1:0] cmd_q;
   logic [OP_WIDTH-1:0]  opa_q, opb_q;
   logic [1:0]           req_q, got_q;
   logic [TCW-1:0]       tcnt;
   logic [WCW-1:0]       wcnt;

   logic [1:0]           cls_req, new_req;
   logic                 cls_mul, cls_legal;
   logic                 accept, same_op;

   logic                 ld_mode, ld_cin, ld_mul;
   logic [CMD_WIDTH-1:0] ld_cmd;
   logic [1:0]           ld_req, ld_got;
   logic [OP_WIDTH-1:0]  ld_opa, ld_opb;
   logic                 fresh, complete, expire, go_issue, drop;

   alu_cmd_classifier #(.CMD_WIDTH(CMD_WIDTH)) u_cls (
      .mode        (bus.in_mode),
      .cmd         (bus.in_cmd),
      .req_mask_c  (cls_req),
      .is_mul_c    (cls_mul),
      .cmd_legal_c (cls_legal)
   );

   // illegal commands pass through with whatever operands the beat carries
   assign new_req = cls_legal ? cls_req : bus.in_inp_valid;
   assign accept  = bus.in_valid && bus.in_ready;
   assign same_op = (bus.in_mode == mode_q) && (bus.in_cmd == cmd_q);

   // Operation context after this cycle's beat: a fresh start or a merge into the pending one
   always_comb begin
      fresh   = accept && ((state == IDLE) || !same_op);
      ld_mode = mode_q;
      ld_cmd  = cmd_q;
      ld_cin  = cin_q;
      ld_mul  = mul_q;
      ld_req  = req_q;
      ld_got  = got_q;
      ld_opa  = opa_q;
      ld_opb  = opb_q;
      if (fresh) begin
         ld_mode = bus.in_mode;
         ld_cmd  = bus.in_cmd;
         ld_cin  = bus.in_cin;
         ld_mul  = cls_mul;
         ld_req  = new_req;
         ld_got  = new_req & bus.in_inp_valid;
         ld_opa  = bus.in_inp_valid[0] ? bus.in_opa : '0;
         ld_opb  = bus.in_inp_valid[1] ? bus.in_opb : '0;
      end else if (accept) begin
         ld_cin = bus.in_cin;
         ld_got = got_q | (bus.in_inp_valid & req_q);
         if (bus.in_inp_valid[0]) ld_opa = bus.in_opa;
         if (bus.in_inp_valid[1]) ld_opb = bus.in_opb;
      end
      complete = (fresh || (state == COLLECT)) && (ld_got == ld_req);
      expire   = !fresh && !complete && (state == COLLECT) && (tcnt == TCW'(TIMEOUT));
      go_issue = complete || expire;
      drop     = fresh && (state == COLLECT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         mode_q            <= 1'b0;
         cin_q             <= 1'b0;
         mul_q             <= 1'b0;
         cmd_q             <= '0;
         opa_q             <= '0;
         opb_q             <= '0;
         req_q             <= '0;
         got_q             <= '0;
         tcnt              <= '0;
         wcnt              <= '0;
         bus.in_ready      <= 1'b0;
         bus.alu_ce        <= 1'b0;
         bus.alu_mode      <= 1'b0;
         bus.alu_cmd       <= '0;
         bus.alu_cin       <= 1'b0;
         bus.alu_inp_valid <= '0;
         bus.alu_opa       <= '0;
         bus.alu_opb       <= '0;
         bus.busy          <= 1'b0;
         bus.timeout_pulse <= 1'b0;
         bus.drop_pulse    <= 1'b0;
      end else begin
         bus.alu_ce        <= 1'b0;
         bus.timeout_pulse <= 1'b0;
         bus.drop_pulse    <= drop;
         unique case (state)
            IDLE, COLLECT: begin
               mode_q <= ld_mode;
               cmd_q  <= ld_cmd;
               cin_q  <= ld_cin;
               mul_q  <= ld_mul;
               req_q  <= ld_req;
               got_q  <= ld_got;
               opa_q  <= ld_opa;
               opb_q  <= ld_opb;
               if (go_issue) begin
                  state             <= ISSUE;
                  bus.in_ready      <= 1'b0;
                  bus.busy          <= 1'b1;
                  bus.alu_ce        <= 1'b1;
                  bus.alu_mode      <= ld_mode;
                  bus.alu_cmd       <= ld_cmd;
                  bus.alu_cin       <= ld_cin;
                  bus.alu_inp_valid <= ld_got;
                  bus.alu_opa       <= ld_got[0] ? ld_opa : '0;
                  bus.alu_opb       <= ld_got[1] ? ld_opb : '0;
                  bus.timeout_pulse <= expire;
               end else if (fresh) begin
                  state        <= COLLECT;
                  tcnt         <= TCW'(1);
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b1;
               end else if (state == COLLECT) begin
                  tcnt <= tcnt + TCW'(1);
               end else begin
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b0;
               end
            end
            ISSUE: begin
               if (!mul_q && (ALU_LAT == 0)) begin
                  state        <= IDLE;
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b0;
               end else begin
                  state <= WAIT;
                  wcnt  <= mul_q ? WCW'(ALU_LAT + 1) : WCW'(ALU_LAT);
               end
            end
            WAIT: begin
               if (wcnt <= WCW'(1)) begin
                  state        <= IDLE;
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b0;
               end else begin
                  wcnt <= wcnt - WCW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_COLLECTOR_STATS_EN
   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued   <= '0;
         stat_timeouts <= '0;
         stat_drops    <= '0;
      end else begin
         if (go_issue && (stat_issued != '1))  stat_issued   <= stat_issued + STAT_W'(1);
         if (expire && (stat_timeouts != '1))  stat_timeouts <= stat_timeouts + STAT_W'(1);
         if (drop && (stat_drops != '1))       stat_drops    <= stat_drops + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed self-checking bench for alu_operand_collector (ALU_COLLECTOR_STATS_EN optional).
module tb_alu_operand_collector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic seen_ce;

   alu_operand_collector_if #(.OP_WIDTH(8), .CMD_WIDTH(4)) bus ();

`ifdef ALU_COLLECTOR_STATS_EN
   logic [15:0] stat_issued, stat_timeouts, stat_drops;
`endif

   alu_operand_collector #(.OP_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16), .ALU_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ALU_COLLECTOR_STATS_EN
      ,
      .stat_issued   (stat_issued),
      .stat_timeouts (stat_timeouts),
      .stat_drops    (stat_drops)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic m, input logic [3:0] c, input logic ci,
                       input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
      bus.in_valid     = 1'b1;
      bus.in_mode      = m;
      bus.in_cmd       = c;
      bus.in_cin       = ci;
      bus.in_inp_valid = iv;
      bus.in_opa       = a;
      bus.in_opb       = b;
   endtask

   task automatic quiet();
      bus.in_valid     = 1'b0;
      bus.in_inp_valid = 2'b00;
   endtask

   initial begin
      quiet();
      bus.in_mode = 1'b0;
      bus.in_cmd  = 4'd0;
      bus.in_cin  = 1'b0;
      bus.in_opa  = 8'h00;
      bus.in_opb  = 8'h00;

      // reset state
      #3;
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_ce", bus.alu_ce, 0);
      chk("rst_busy", bus.busy, 0);
      tick();
      #2 rst = 1'b0;
      tick();
      chk("idle_ready", bus.in_ready, 1);

      // single-beat ADD
      beat(1'b1, 4'd0, 1'b0, 2'b11, 8'h05, 8'h03);
      tick(); quiet();
      chk("add_ce", bus.alu_ce, 1);
      chk("add_iv", bus.alu_inp_valid, 2'b11);
      chk("add_opa", bus.alu_opa, 8'h05);
      chk("add_opb", bus.alu_opb, 8'h03);
      chk("add_mode_cmd", {bus.alu_mode, bus.alu_cmd}, 5'b1_0000);
      chk("add_ready_issue", bus.in_ready, 0);
      tick();
      chk("add_ce_wait", bus.alu_ce, 0);
      chk("add_ready_wait", bus.in_ready, 0);
      chk("add_hold_opa", bus.alu_opa, 8'h05);
      tick();
      chk("add_ready_back", bus.in_ready, 1);
      chk("add_busy_back", bus.busy, 0);

      // split operands AND
      beat(1'b0, 4'd0, 1'b0, 2'b01, 8'hF0, 8'h00);
      tick(); quiet();
      chk("split_collect_ce", bus.alu_ce, 0);
      chk("split_collect_busy", bus.busy, 1);
      repeat (5) tick();
      chk("split_still_ready", bus.in_ready, 1);
      beat(1'b0, 4'd0, 1'b0, 2'b10, 8'h00, 8'h3C);
      tick(); quiet();
      chk("split_ce", bus.alu_ce, 1);
      chk("split_iv", bus.alu_inp_valid, 2'b11);
      chk("split_ops", {bus.alu_opa, bus.alu_opb}, 16'hF03C);
      chk("split_no_to", bus.timeout_pulse, 0);
      repeat (2) tick();

      // timeout on CMP with only opa
      beat(1'b1, 4'd8, 1'b0, 2'b01, 8'h10, 8'h00);
      tick(); quiet();
      repeat (15) tick();
      chk("to_before_ce", bus.alu_ce, 0);
      chk("to_before_pulse", bus.timeout_pulse, 0);
      tick();
      chk("to_pulse", bus.timeout_pulse, 1);
      chk("to_ce", bus.alu_ce, 1);
      chk("to_iv", bus.alu_inp_valid, 2'b01);
      chk("to_ops", {bus.alu_opa, bus.alu_opb}, 16'h1000);
      tick();
      chk("to_pulse_one", bus.timeout_pulse, 0);
      tick();

      // completion on the timeout cycle wins
      beat(1'b1, 4'd8, 1'b0, 2'b01, 8'h11, 8'h00);
      tick(); quiet();
      repeat (15) tick();
      beat(1'b1, 4'd8, 1'b0, 2'b10, 8'h00, 8'h22);
      tick(); quiet();
      chk("race_ce", bus.alu_ce, 1);
      chk("race_no_to", bus.timeout_pulse, 0);
      chk("race_iv", bus.alu_inp_valid, 2'b11);
      repeat (2) tick();

      // drop: SUB_CIN partial, then NOT_B
      beat(1'b1, 4'd3, 1'b1, 2'b01, 8'h77, 8'h00);
      tick();
      beat(1'b0, 4'd7, 1'b0, 2'b10, 8'h55, 8'hAA);
      tick(); quiet();
      chk("drop_pulse", bus.drop_pulse, 1);
      chk("drop_no_to", bus.timeout_pulse, 0);
      chk("drop_ce", bus.alu_ce, 1);
      chk("drop_mode_cmd", {bus.alu_mode, bus.alu_cmd}, 5'b0_0111);
      chk("drop_iv", bus.alu_inp_valid, 2'b10);
      chk("drop_ops", {bus.alu_opa, bus.alu_opb}, 16'h00AA);
      tick();
      chk("drop_pulse_one", bus.drop_pulse, 0);
      tick();

      // unary INC_B with both operands present: opa masked to 0
      beat(1'b1, 4'd6, 1'b0, 2'b11, 8'h99, 8'h42);
      tick(); quiet();
      chk("incb_iv", bus.alu_inp_valid, 2'b10);
      chk("incb_ops", {bus.alu_opa, bus.alu_opb}, 16'h0042);
      repeat (2) tick();

      // illegal arithmetic command passes inp_valid through
      beat(1'b1, 4'd15, 1'b0, 2'b01, 8'h5A, 8'h00);
      tick(); quiet();
      chk("ill_ce", bus.alu_ce, 1);
      chk("ill_iv", bus.alu_inp_valid, 2'b01);
      repeat (2) tick();

      // INC_MUL: in_ready low for 3 cycles
      beat(1'b1, 4'd9, 1'b0, 2'b11, 8'h03, 8'h04);
      tick(); quiet();
      chk("mul_ce", bus.alu_ce, 1);
      chk("mul_ready1", bus.in_ready, 0);
      tick();
      chk("mul_ready2", bus.in_ready, 0);
      tick();
      chk("mul_ready3", bus.in_ready, 0);
      chk("mul_ce_wait", bus.alu_ce, 0);
      tick();
      chk("mul_ready_back", bus.in_ready, 1);

      // async reset while collecting
      beat(1'b0, 4'd0, 1'b0, 2'b01, 8'hC3, 8'h00);
      tick(); quiet();
      chk("rc_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rc_busy0", bus.busy, 0);
      chk("rc_ready0", bus.in_ready, 0);
      chk("rc_alu0", {bus.alu_ce, bus.alu_mode, bus.alu_cmd, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb}, 0);
`ifdef ALU_COLLECTOR_STATS_EN
      chk("rc_stats0", {stat_issued, stat_timeouts, stat_drops}, 0);
`endif
      @(posedge clk);
      #2 rst = 1'b0;
      seen_ce = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick();
         seen_ce = seen_ce | bus.alu_ce | bus.timeout_pulse;
      end
      chk("rc_no_issue", seen_ce, 0);
      chk("rc_idle_ready", bus.in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
